// File: rtl/usb_rx_bank_sched_if.sv
// usb_rx_bank_sched_if: USB byte stream, consumer handshake and RX buffer RAM port bundle.
// slave is the scheduler's view; master is the surrounding logic (USB core, consumer, RAM).
interface usb_rx_bank_sched_if #(
  parameter int unsigned ADDR_W = 6
);
  // USB side
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              frame_end;
  logic              frame_ok;
  // Consumer side
  logic              rd_req;
  logic              rd_valid;
  logic [7:0]        rd_data;
  logic              rd_last;
  logic              frame_avail;
  logic              drop;
  // RAM side
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_wren;
  logic              ram_rden;
  logic [7:0]        ram_q;

  modport slave (
    input  wr_en, wr_data, frame_end, frame_ok, rd_req, ram_q,
    output rd_valid, rd_data, rd_last, frame_avail, drop,
    output ram_addr, ram_data, ram_wren, ram_rden
  );

  modport master (
    output wr_en, wr_data, frame_end, frame_ok, rd_req, ram_q,
    input  rd_valid, rd_data, rd_last, frame_avail, drop,
    input  ram_addr, ram_data, ram_wren, ram_rden
  );
endinterface

// File: rtl/usb_rx_bank_sched.sv
// usb_rx_bank_sched: ping-pong scheduler for the single-port USB RX buffer RAM.
// The RAM is split into two banks (address MSB). One bank fills from the USB byte stream while
// the other drains to the consumer; header and CRC bytes are stripped on drain, and bad, runt
// or overflowing frames are discarded with a one-cycle drop pulse. The writer always owns the
// RAM port when it has a byte.
// Optional feature: define USB_RX_SCHED_STATS_EN to add ok_cnt/drop_cnt frame counters.
module usb_rx_bank_sched #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned HDR_SKIP  = 6,
  parameter int unsigned TAIL_SKIP = 1
) (
  input  logic                     clk,
  input  logic                     n_rst,
  usb_rx_bank_sched_if.slave       bus
`ifdef USB_RX_SCHED_STATS_EN
  ,
  output logic [15:0]              ok_cnt,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int unsigned BW = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] BSZ_C    = ADDR_W'(2 ** (ADDR_W - 1));
  localparam logic [ADDR_W-1:0] MIN_LEN  = ADDR_W'(HDR_SKIP + TAIL_SKIP);
  localparam logic [ADDR_W-1:0] LAST_OFS = ADDR_W'(TAIL_SKIP + 1);
  localparam logic [BW-1:0]     RP_START = BW'(HDR_SKIP);

  typedef enum logic [1:0] {StFree, StFill, StFull, StDrain} bank_st_e;

  bank_st_e          bank_st_q [2];
  logic [ADDR_W-1:0] len_q     [2];
  logic              wb_q;        // bank being filled
  logic              rb_q;        // bank being drained
  logic [ADDR_W-1:0] cnt_q;       // bytes written into wb for the current frame
  logic              bad_q;       // current frame lost a byte
  logic              got_q;       // current frame has seen at least one byte
  logic [BW-1:0]     rp_q;        // next read offset within rb
  logic              rd_done_q;   // final byte issued, waiting for its return
  logic              rd_valid_q;
  logic              rd_last_q;
  logic              drop_q;

  logic              wb_open;
  logic              wr_do;
  logic              wr_drop;
  logic [ADDR_W-1:0] cnt_nx;
  logic              rb_ready;
  logic              rd_do;
  logic [ADDR_W-1:0] last_idx;
  logic              rd_is_last;
  logic              any_byte;
  logic              frame_bad;
  logic              good_end;
  logic              bad_end;

  // Write acceptance, read issue and frame verdict for this cycle
  always_comb begin
    wb_open    = (bank_st_q[wb_q] == StFree) || (bank_st_q[wb_q] == StFill);
    wr_do      = bus.wr_en && wb_open && (cnt_q < BSZ_C);
    wr_drop    = bus.wr_en && !wr_do;
    cnt_nx     = cnt_q + ADDR_W'(wr_do);
    rb_ready   = ((bank_st_q[rb_q] == StFull) || (bank_st_q[rb_q] == StDrain)) && !rd_done_q;
    rd_do      = rb_ready && bus.rd_req && !bus.wr_en;
    last_idx   = len_q[rb_q] - LAST_OFS;
    rd_is_last = ({1'b0, rp_q} == last_idx);
    any_byte   = got_q || bus.wr_en;
    // Length counts the same-cycle byte; a frame that lost any byte is never delivered
    frame_bad  = !bus.frame_ok || bad_q || wr_drop || (cnt_nx <= MIN_LEN);
    good_end   = bus.frame_end && any_byte && !frame_bad;
    bad_end    = bus.frame_end && any_byte && frame_bad;
  end

  // RAM port: writer has absolute priority, read address otherwise
  always_comb begin
    bus.ram_wren    = wr_do;
    bus.ram_rden    = rd_do;
    bus.ram_data    = bus.wr_data;
    bus.ram_addr    = bus.wr_en ? {wb_q, cnt_q[BW-1:0]} : {rb_q, rp_q};
    bus.rd_valid    = rd_valid_q;
    bus.rd_last     = rd_last_q;
    bus.rd_data     = bus.ram_q;
    bus.drop        = drop_q;
    bus.frame_avail = (bank_st_q[rb_q] == StFull) || (bank_st_q[rb_q] == StDrain);
  end

  // Bank state machine plus fill and drain pointers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 2; i++) begin
        bank_st_q[i] <= StFree;
        len_q[i]     <= '0;
      end
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      cnt_q      <= '0;
      bad_q      <= 1'b0;
      got_q      <= 1'b0;
      rp_q       <= RP_START;
      rd_done_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      drop_q     <= 1'b0;
      rd_valid_q <= rd_do;
      rd_last_q  <= rd_do && rd_is_last;

      // Fill side only touches FREE/FILL banks, drain side only FULL/DRAIN banks
      if (bad_end || good_end) begin
        cnt_q <= '0;
        bad_q <= 1'b0;
        got_q <= 1'b0;
        if (good_end) begin
          bank_st_q[wb_q] <= StFull;
          len_q[wb_q]     <= cnt_nx;
          wb_q            <= ~wb_q;
        end else begin
          // A frame dropped entirely against a held bank must leave that bank alone
          if (wb_open) bank_st_q[wb_q] <= StFree;
          drop_q <= 1'b1;
        end
      end else begin
        if (wr_do) begin
          cnt_q <= cnt_nx;
          if (bank_st_q[wb_q] == StFree) bank_st_q[wb_q] <= StFill;
        end
        if (bus.wr_en) got_q <= 1'b1;
        if (wr_drop) bad_q <= 1'b1;
      end

      if (rd_do) begin
        bank_st_q[rb_q] <= StDrain;
        if (rd_is_last) begin
          rd_done_q <= 1'b1;
          rp_q      <= RP_START;
        end else begin
          rp_q <= rp_q + BW'(1);
        end
      end

      // Final byte is on rd_data now: release the bank
      if (rd_last_q) begin
        bank_st_q[rb_q] <= StFree;
        rb_q            <= ~rb_q;
        rd_done_q       <= 1'b0;
      end
    end
  end

`ifdef USB_RX_SCHED_STATS_EN
  // Good/dropped frame counters, wrap naturally
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ok_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (good_end) ok_cnt <= ok_cnt + 16'd1;
      if (drop_q) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb_rx_bank_sched.sv
// tb_usb_rx_bank_sched: directed bench for usb_rx_bank_sched with a 1-cycle-latency RAM model.
module tb_usb_rx_bank_sched;

  logic clk;
  logic n_rst;

  usb_rx_bank_sched_if #(.ADDR_W(6)) bus ();

`ifdef USB_RX_SCHED_STATS_EN
  logic [15:0] ok_cnt;
  logic [15:0] drop_cnt;
`endif

  usb_rx_bank_sched #(
    .ADDR_W   (6),
    .HDR_SKIP (6),
    .TAIL_SKIP(1)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
`ifdef USB_RX_SCHED_STATS_EN
    ,
    .ok_cnt  (ok_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model
  logic [7:0] mem [64];
  logic [7:0] ram_q_r;
  assign bus.ram_q = ram_q_r;
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_data;
    if (bus.ram_rden) ram_q_r <= mem[bus.ram_addr];
  end

  // Monitor
  logic [7:0] rx_data [$];
  logic       rx_last [$];
  int         drops;
  int         collide;
  always @(negedge clk) begin
    if (bus.rd_valid) begin
      rx_data.push_back(bus.rd_data);
      rx_last.push_back(bus.rd_last);
    end
    if (bus.drop) drops++;
    if (bus.ram_wren && bus.ram_rden) collide++;
  end

  int errors = 0;
  int checks = 0;
  logic [7:0] fb [64];
  int d0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Header 5e 4d 01 00 <payload len> b4, payload start.., CRC 2f
  task automatic build(input int n, input logic [7:0] start);
    fb[0] = 8'h5e; fb[1] = 8'h4d; fb[2] = 8'h01; fb[3] = 8'h00;
    fb[4] = 8'(n - 7); fb[5] = 8'hb4;
    for (int i = 6; i < n - 1; i++) fb[i] = start + 8'(i - 6);
    fb[n-1] = 8'h2f;
  endtask

  task automatic send(input int n, input bit ok, input bit gap);
    for (int i = 0; i < n; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = fb[i];
      bus.frame_end = (i == n - 1); bus.frame_ok = ok;
      step();
      bus.wr_en = 1'b0; bus.frame_end = 1'b0; bus.frame_ok = 1'b0;
      if (gap) step();
    end
  endtask

  task automatic wait_rx(input string tag, input int n);
    for (int c = 0; c < 300 && rx_data.size() < n; c++) step();
    chk(tag, rx_data.size(), n);
  endtask

  task automatic expect_pl(input string tag, input int base, input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      if (base + i < rx_data.size()) begin
        chk({tag, "_data"}, rx_data[base+i], start + 8'(i));
        chk({tag, "_last"}, rx_last[base+i], (i == n - 1));
      end
    end
  endtask

  initial begin
    n_rst = 1'b0;
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.frame_end = 1'b0;
    bus.frame_ok = 1'b0; bus.rd_req = 1'b0;
    drops = 0; collide = 0;
    step(); step();
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_rd_last", bus.rd_last, 1'b0);
    chk("rst_frame_avail", bus.frame_avail, 1'b0);
    chk("rst_drop", bus.drop, 1'b0);
    chk("rst_ram_wren", bus.ram_wren, 1'b0);
    chk("rst_ram_rden", bus.ram_rden, 1'b0);
    n_rst = 1'b1;
    step();

    // T1: good frame delivered 01..06
    bus.rd_req = 1'b1;
    build(13, 8'h01);
    chk("t1_hdr_len", fb[4], 8'h06);
    send(13, 1'b1, 1'b0);
    chk("t1_avail", bus.frame_avail, 1'b1);
    wait_rx("t1_count", 6);
    expect_pl("t1", 0, 8'h01, 6);
    step(); step();
    chk("t1_avail_after", bus.frame_avail, 1'b0);
    chk("t1_no_drop", drops, 0);

    // T2: bad CRC dropped, bank reusable
    rx_data.delete(); rx_last.delete();
    build(13, 8'h01);
    send(13, 1'b0, 1'b0);
    chk("t2_avail", bus.frame_avail, 1'b0);
    chk("t2_drop_hi", bus.drop, 1'b1);
    step();
    chk("t2_drop_lo", bus.drop, 1'b0);
    chk("t2_drops", drops, 1);
    build(13, 8'h11);
    send(13, 1'b1, 1'b0);
    wait_rx("t2_reuse_count", 6);
    expect_pl("t2_reuse", 0, 8'h11, 6);

    // T3: two frames held, third dropped, then drained in order
    step(); step();
    rx_data.delete(); rx_last.delete();
    bus.rd_req = 1'b0;
    d0 = drops;
    build(13, 8'h21); send(13, 1'b1, 1'b0); step();
    build(10, 8'h41); send(10, 1'b1, 1'b0); step();
    build(13, 8'h61); send(13, 1'b1, 1'b0);
    chk("t3_drop_hi", bus.drop, 1'b1);
    step(); step();
    chk("t3_drops", drops - d0, 1);
    chk("t3_none_read", rx_data.size(), 0);
    chk("t3_avail", bus.frame_avail, 1'b1);
    bus.rd_req = 1'b1;
    wait_rx("t3_count", 9);
    expect_pl("t3_f1", 0, 8'h21, 6);
    expect_pl("t3_f2", 6, 8'h41, 3);

    // T4: drain while writer takes every other cycle
    step(); step();
    rx_data.delete(); rx_last.delete();
    bus.rd_req = 1'b0;
    build(13, 8'hc1); send(13, 1'b1, 1'b0);
    bus.rd_req = 1'b1;
    build(13, 8'hd1); send(13, 1'b1, 1'b1);
    wait_rx("t4_count", 12);
    expect_pl("t4_x", 0, 8'hc1, 6);
    expect_pl("t4_y", 6, 8'hd1, 6);
    chk("t4_no_collide", collide, 0);

    // T5: overflow, runt, and the two length boundaries that are kept
    step(); step();
    rx_data.delete(); rx_last.delete();
    d0 = drops;
    build(40, 8'h80); send(40, 1'b1, 1'b0);
    chk("t5_ovf_drop", bus.drop, 1'b1);
    step();
    build(7, 8'h00); send(7, 1'b1, 1'b0);
    chk("t5_runt_drop", bus.drop, 1'b1);
    step(); step(); step();
    chk("t5_drops", drops - d0, 2);
    chk("t5_no_rd", rx_data.size(), 0);
    chk("t5_avail", bus.frame_avail, 1'b0);
    build(8, 8'h90); send(8, 1'b1, 1'b0);
    wait_rx("t5_len8_count", 1);
    expect_pl("t5_len8", 0, 8'h90, 1);
    build(32, 8'ha0); send(32, 1'b1, 1'b0);
    wait_rx("t5_len32_count", 26);
    expect_pl("t5_len32", 1, 8'ha0, 25);
    chk("t5_no_more_drops", drops - d0, 2);

    // T6: reset mid-drain abandons silently
    step(); step();
    rx_data.delete(); rx_last.delete();
    d0 = drops;
    build(13, 8'h51); send(13, 1'b1, 1'b0);
    for (int c = 0; c < 50 && rx_data.size() < 2; c++) step();
    chk("t6_started", rx_data.size(), 2);
    n_rst = 1'b0;
    #1;
    chk("t6_rst_rd_valid", bus.rd_valid, 1'b0);
    chk("t6_rst_rd_last", bus.rd_last, 1'b0);
    chk("t6_rst_avail", bus.frame_avail, 1'b0);
    chk("t6_rst_drop", bus.drop, 1'b0);
    chk("t6_rst_wren", bus.ram_wren, 1'b0);
    chk("t6_rst_rden", bus.ram_rden, 1'b0);
    step();
    n_rst = 1'b1;
    step();
    rx_data.delete(); rx_last.delete();
    build(13, 8'h71); send(13, 1'b1, 1'b0);
    wait_rx("t6_count", 6);
    expect_pl("t6", 0, 8'h71, 6);
    step(); step();
    chk("t6_no_drop", drops - d0, 0);
    chk("t6_exact_count", rx_data.size(), 6);
`ifdef USB_RX_SCHED_STATS_EN
    chk("stats_ok_cnt", ok_cnt, 16'd1);
    chk("stats_drop_cnt", drop_cnt, 16'd0);
`endif
    chk("no_collide", collide, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
